// File: rtl/safecrack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : safecrack_pkg
// Description : Shared types and helpers for the parametrised safe lock.
//               The state encoding is one-hot. The PROG state is used only
//               when SAFECRACK_REPROG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package safecrack_pkg;

  typedef enum logic [4:0] {
    ST_ENTRY   = 5'b00001,
    ST_OPEN    = 5'b00010,
    ST_ERROR   = 5'b00100,
    ST_LOCKOUT = 5'b01000,
    ST_PROG    = 5'b10000
  } state_t;

  // The smallest width allowed for any index or counter field
  localparam int unsigned MIN_W = 1;

  // The products are 64-bit so that large clock rates cannot overflow before truncation
  function automatic longint unsigned sec_to_cycles(input longint unsigned sec,
                                                    input longint unsigned clk_hz);
    return sec * clk_hz;
  endfunction

  // Bits needed to index n distinct values. The result is never below one bit
  function automatic int unsigned bits_for(input longint unsigned n);
    return (n <= 2) ? MIN_W : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/safecrack_btn_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : btn_edge_det
// Description : Inverts the active-low buttons and passes them through a
//               2-flop synchroniser. It then outputs a one-cycle rising-edge
//               pulse per button. All flops reset to "pressed", so a button
//               held across reset release gives no edge.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_edge_det #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] btn_n,
  output logic [W-1:0] rise
);

  logic [W-1:0] sync1_q, sync1_d;
  logic [W-1:0] sync2_q, sync2_d;
  logic [W-1:0] prev_q,  prev_d;

  // Next-state values for the synchroniser chain and the history flop
  always_comb begin
    sync1_d = ~btn_n;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Synchroniser and history registers, reset to the all-pressed value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/safecrack_param.sv
`default_nettype none
// ============================================================================
// Module      : safecrack_param
// Description : Parametrised combination-lock controller.
//               - The user enters CODE_LEN digits on N_BTN active-low buttons.
//               - The verdict is given only after the full code is entered.
//               - MAX_FAILS consecutive failures cause a timed lockout.
//               - Optional code reprogramming is available from OPEN.
//               Macro SAFECRACK_REPROG_EN enables the prog_req port and the
//               PROG state.
// Revision    : 1.0 - initial release
// ============================================================================
module safecrack_param
  import safecrack_pkg::*;
#(
  parameter int unsigned N_BTN     = 4,
  parameter int unsigned CODE_LEN  = 4,
  // Digit 0 is in the LSBs. The default code is entered as 0,1,2,3
  parameter logic [CODE_LEN*bits_for(N_BTN)-1:0] CODE_INIT = {2'd3, 2'd2, 2'd1, 2'd0},
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned OK_SEC    = 5,
  parameter int unsigned ERR_SEC   = 3,
  parameter int unsigned MAX_FAILS = 3,
  parameter int unsigned LOCK_SEC  = 30
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [N_BTN-1:0]               btn,
`ifdef SAFECRACK_REPROG_EN
  input  logic                           prog_req,
`endif
  output logic [CODE_LEN-1:0]            leds_verde,
  output logic                           led_vermelho,
  output logic                           led_lock,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt
);

  localparam int unsigned DIG_W  = bits_for(N_BTN);
  localparam int unsigned CODE_W = CODE_LEN * DIG_W;
  localparam int unsigned IDX_W  = bits_for(CODE_LEN);
  localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);

  localparam longint unsigned OK_CYC   = sec_to_cycles(OK_SEC,   CLK_HZ);
  localparam longint unsigned ERR_CYC  = sec_to_cycles(ERR_SEC,  CLK_HZ);
  localparam longint unsigned LOCK_CYC = sec_to_cycles(LOCK_SEC, CLK_HZ);
  localparam longint unsigned MAX_A    = (OK_CYC > ERR_CYC) ? OK_CYC : ERR_CYC;
  localparam longint unsigned MAX_CYC  = (MAX_A > LOCK_CYC) ? MAX_A : LOCK_CYC;
  localparam int unsigned     TMR_W    = bits_for(MAX_CYC);

  // The timer loads SEC*CLK_HZ-1 and exits when it reaches 0. The dwell is therefore exactly SEC*CLK_HZ cycles
  localparam logic [TMR_W-1:0]  OK_LOAD   = TMR_W'(OK_CYC - 1);
  localparam logic [TMR_W-1:0]  ERR_LOAD  = TMR_W'(ERR_CYC - 1);
  localparam logic [TMR_W-1:0]  LOCK_LOAD = TMR_W'(LOCK_CYC - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAILS);
  localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAILS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(CODE_LEN - 1);
  localparam logic [N_BTN-1:0]  BTN_ONE   = N_BTN'(1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q,   idx_d;
  logic                mis_q,   mis_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [FAIL_W-1:0]   fail_q,  fail_d;

  logic [N_BTN-1:0]    btn_rise;
  logic                any_rise;
  logic [DIG_W-1:0]    cur_digit;
  logic                digit_ok;
  logic                mis_next;
  logic [CODE_W-1:0]   code_cur;

  btn_edge_det #(.W(N_BTN)) u_edge (
    .clk   (clk),
    .rst_n (rstn),
    .btn_n (btn),
    .rise  (btn_rise)
  );

`ifdef SAFECRACK_REPROG_EN
  logic [CODE_W-1:0]   code_q,   code_d;
  logic [CODE_W-1:0]   shadow_q, shadow_d;
  logic [CODE_W-1:0]   shadow_ins;
  logic [DIG_W-1:0]    rise_digit;
  logic                rise_onehot;

  assign code_cur    = code_q;
  assign rise_onehot = $onehot(btn_rise);

  // Encode the single pressed button as a digit and merge it into the shadow code at idx
  always_comb begin
    rise_digit = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (btn_rise[i]) rise_digit = DIG_W'(i);
    end
    shadow_ins = shadow_q;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (idx_q == IDX_W'(i)) shadow_ins[i*DIG_W +: DIG_W] = rise_digit;
    end
  end
`else
  assign code_cur = CODE_INIT;
`endif

  assign any_rise = |btn_rise;
  assign mis_next = mis_q | ~digit_ok;

  // Select the expected digit. A multi-hot edge cannot equal the one-hot pattern, so it never matches
  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (idx_q == IDX_W'(i)) cur_digit = code_cur[i*DIG_W +: DIG_W];
    end
    digit_ok = (btn_rise == (BTN_ONE << cur_digit));
  end

  // Next-state logic for the FSM, the digit index, the mismatch flag, the timer and the failure count
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mis_d   = mis_q;
    timer_d = timer_q;
    fail_d  = fail_q;
`ifdef SAFECRACK_REPROG_EN
    code_d   = code_q;
    shadow_d = shadow_q;
`endif
    case (state_q)
      ST_ENTRY: begin
        if (any_rise) begin
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            mis_d = 1'b0;
            if (!mis_next) begin
              state_d = ST_OPEN;
              timer_d = OK_LOAD;
              fail_d  = '0;
            end else begin
              fail_d = (fail_q == FAIL_MAX) ? FAIL_MAX : fail_q + FAIL_W'(1);
              if (fail_q == FAIL_LAST) begin
                state_d = ST_LOCKOUT;
                timer_d = LOCK_LOAD;
              end else begin
                state_d = ST_ERROR;
                timer_d = ERR_LOAD;
              end
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
            mis_d = mis_next;
          end
        end
      end
      ST_OPEN: begin
`ifdef SAFECRACK_REPROG_EN
        if (prog_req) begin
          state_d = ST_PROG;
          idx_d   = '0;
        end else
`endif
        if (timer_q == '0) state_d = ST_ENTRY;
        else               timer_d = timer_q - TMR_W'(1);
      end
      ST_ERROR: begin
        if (timer_q == '0) state_d = ST_ENTRY;
        else               timer_d = timer_q - TMR_W'(1);
      end
      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = ST_ENTRY;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
`ifdef SAFECRACK_REPROG_EN
      ST_PROG: begin
        if (any_rise) begin
          if (!rise_onehot) begin
            // A malformed entry abandons programming and leaves the stored code untouched
            state_d = ST_ERROR;
            timer_d = ERR_LOAD;
            idx_d   = '0;
          end else begin
            shadow_d = shadow_ins;
            if (idx_q == IDX_LAST) begin
              code_d  = shadow_ins;
              state_d = ST_ENTRY;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
      end
`endif
      default: begin
        state_d = ST_ENTRY;
        idx_d   = '0;
        mis_d   = 1'b0;
        timer_d = '0;
      end
    endcase
  end

  // State registers. Reset aborts any entry or timed hold immediately
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_ENTRY;
      idx_q    <= '0;
      mis_q    <= 1'b0;
      timer_q  <= '0;
      fail_q   <= '0;
`ifdef SAFECRACK_REPROG_EN
      code_q   <= CODE_INIT;
      shadow_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mis_q    <= mis_d;
      timer_q  <= timer_d;
      fail_q   <= fail_d;
`ifdef SAFECRACK_REPROG_EN
      code_q   <= code_d;
      shadow_q <= shadow_d;
`endif
    end
  end

  // Decode the outputs from the registered state. The green LEDs show a thermometer of digits entered
  always_comb begin
    leds_verde = '0;
    if (state_q == ST_OPEN) begin
      leds_verde = '1;
    end else if (state_q == ST_ENTRY || state_q == ST_PROG) begin
      for (int i = 0; i < CODE_LEN; i++) begin
        leds_verde[i] = (idx_q > IDX_W'(i));
      end
    end
  end

  assign led_vermelho = (state_q == ST_ERROR);
  assign led_lock     = (state_q == ST_LOCKOUT);
  assign fail_cnt     = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_safecrack_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_safecrack_param
// Description : Self-checking bench for safecrack_param with CLK_HZ = 10.
//               A digit-level reference model predicts the LEDs, the failure
//               count and the hold durations. Macro SAFECRACK_REPROG_EN adds
//               the reprogramming scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_safecrack_param;

  localparam int N_BTN     = 4;
  localparam int CODE_LEN  = 4;
  localparam int TB_HZ     = 10;
  localparam int MAX_FAILS = 3;
  localparam int OPEN_CYC  = 5 * TB_HZ;
  localparam int ERR_CYC   = 3 * TB_HZ;
  localparam int LOCK_CYC  = 30 * TB_HZ;
  localparam int V_NONE = 0, V_OPEN = 1, V_ERR = 2, V_LOCK = 3;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] btn;
  logic [3:0] leds_verde;
  logic       led_vermelho;
  logic       led_lock;
  logic [1:0] fail_cnt;
`ifdef SAFECRACK_REPROG_EN
  logic       prog_req;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state. A pending digit of -1 is a multi-hot entry
  int m_code[CODE_LEN];
  int m_buf[$];
  int m_fails;
  bit m_prog;

  always #5 clk = ~clk;

  safecrack_param #(.CLK_HZ(TB_HZ)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .btn          (btn),
`ifdef SAFECRACK_REPROG_EN
    .prog_req     (prog_req),
`endif
    .leds_verde   (leds_verde),
    .led_vermelho (led_vermelho),
    .led_lock     (led_lock),
    .fail_cnt     (fail_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] e_leds, input bit e_red,
                            input bit e_lock, input int e_fail);
    check({tag, ".leds"}, 32'(leds_verde),   32'(e_leds));
    check({tag, ".red"},  32'(led_vermelho), 32'(e_red));
    check({tag, ".lock"}, 32'(led_lock),     32'(e_lock));
    check({tag, ".fail"}, 32'(fail_cnt),     32'(e_fail));
  endtask

  function automatic int mask_digit(input logic [3:0] m);
    if ($countones(m) != 1) return -1;
    for (int i = 0; i < N_BTN; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic logic [3:0] thermo(input int n);
    return 4'((1 << n) - 1);
  endfunction

  task automatic model_reset();
    m_code = '{0, 1, 2, 3};
    m_buf.delete();
    m_fails = 0;
    m_prog  = 1'b0;
  endtask

  // This task applies one digit to the model and returns the verdict for that press
  task automatic model_step(input int d, output int verdict);
    bit ok;
    verdict = V_NONE;
    if (m_prog) begin
      if (d < 0) begin
        m_prog = 1'b0;
        m_buf.delete();
        verdict = V_ERR;
      end else begin
        m_buf.push_back(d);
        if (m_buf.size() == CODE_LEN) begin
          for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_buf[i];
          m_buf.delete();
          m_prog = 1'b0;
        end
      end
    end else begin
      m_buf.push_back(d);
      if (m_buf.size() == CODE_LEN) begin
        ok = 1'b1;
        for (int i = 0; i < CODE_LEN; i++) if (m_buf[i] != m_code[i]) ok = 1'b0;
        m_buf.delete();
        if (ok) begin
          m_fails = 0;
          verdict = V_OPEN;
        end else begin
          m_fails++;
          verdict = (m_fails >= MAX_FAILS) ? V_LOCK : V_ERR;
        end
      end
    end
  endtask

  function automatic bit hold_active(input int kind);
    case (kind)
      V_OPEN:  return leds_verde == 4'hF;
      V_ERR:   return led_vermelho;
      default: return led_lock;
    endcase
  endfunction

  // This task counts the cycles for which the hold indication stays up, optionally pressing buttons during it
  task automatic hold(input int kind, input bit inject, output int cnt);
    cnt = 0;
    while (cnt < 2000 && hold_active(kind)) begin
      cnt++;
      if (inject && cnt < LOCK_CYC - 50 && ($urandom_range(0, 3) == 0))
        btn = ~4'($urandom_range(1, 15));
      else
        btn = 4'hF;
      @(negedge clk);
    end
    btn = 4'hF;
  endtask

  // This task presses the buttons in mask, checks the response once the edge has reached the FSM, and measures any hold
  task automatic do_press(input logic [3:0] mask, input bit hold_en);
    int verdict, cnt;
    @(negedge clk) btn = ~mask;
    @(negedge clk);
    @(negedge clk) btn = 4'hF;
    @(negedge clk);
    model_step(mask_digit(mask), verdict);
    case (verdict)
      V_NONE: check_outs("digit", thermo(m_buf.size()), 1'b0, 1'b0, m_fails);
      V_OPEN: check_outs("open", 4'hF, 1'b0, 1'b0, 0);
      V_ERR:  check_outs("error", 4'h0, 1'b1, 1'b0, m_fails);
      default: check_outs("lockout", 4'h0, 1'b0, 1'b1, MAX_FAILS);
    endcase
    if (verdict != V_NONE && hold_en) begin
      hold(verdict, verdict == V_LOCK, cnt);
      case (verdict)
        V_OPEN:  check("open_len", 32'(cnt), 32'(OPEN_CYC));
        V_ERR:   check("error_len", 32'(cnt), 32'(ERR_CYC));
        default: check("lock_len", 32'(cnt), 32'(LOCK_CYC));
      endcase
      if (verdict == V_LOCK) m_fails = 0;
      check_outs("after_hold", 4'h0, 1'b0, 1'b0, m_fails);
    end
  endtask

  task automatic enter_code(input int d0, input int d1, input int d2, input int d3);
    do_press(4'(1) << d0, 1'b1);
    do_press(4'(1) << d1, 1'b1);
    do_press(4'(1) << d2, 1'b1);
    do_press(4'(1) << d3, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk) rstn = 1'b0;
    #1 check_outs("in_reset", 4'h0, 1'b0, 1'b0, 0);
    @(negedge clk) rstn = 1'b1;
    model_reset();
    @(negedge clk);
    check_outs("post_reset", 4'h0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    logic [3:0] mask;
    int kind;
    btn  = 4'hF;
    rstn = 1'b0;
`ifdef SAFECRACK_REPROG_EN
    prog_req = 1'b0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    check_outs("reset", 4'h0, 1'b0, 1'b0, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Correct code with single presses
    enter_code(0, 1, 2, 3);
    // Wrong code: the thermometer keeps advancing and the verdict comes only after the 4th press
    enter_code(0, 3, 2, 1);
    // Clear the failure count, then enter three wrong codes in a row to reach lockout
    enter_code(0, 1, 2, 3);
    enter_code(1, 1, 1, 1);
    enter_code(3, 2, 1, 0);
    enter_code(0, 1, 2, 2);

    // Two buttons in the same cycle as digit 0
    do_press(4'b0011, 1'b1);
    do_press(4'b0010, 1'b1);
    do_press(4'b0100, 1'b1);
    do_press(4'b1000, 1'b1);

    // Button held through reset release produces no edge
    @(negedge clk) btn = ~4'b0001;
    do_reset();
    btn = ~4'b0001;
    repeat (5) @(negedge clk);
    check("held_no_edge", 32'(leds_verde), 32'h0);
    btn = 4'hF;
    repeat (5) @(negedge clk);
    check("release_no_edge", 32'(leds_verde), 32'h0);

    // Reset while in the middle of an entry (idx = 2)
    do_press(4'b0001, 1'b1);
    do_press(4'b0010, 1'b1);
    do_reset();

    // Reset in the middle of OPEN
    do_press(4'b0001, 1'b1);
    do_press(4'b0010, 1'b1);
    do_press(4'b0100, 1'b1);
    do_press(4'b1000, 1'b0);
    repeat (10) @(negedge clk);
    check("mid_open", 32'(leds_verde), 32'hF);
    do_reset();

    // Random codes, including the correct code, wrong codes and multi-hot presses
    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 3);
      for (int k = 0; k < CODE_LEN; k++) begin
        if (kind == 0) mask = 4'(1) << m_code[k];
        else           mask = 4'(1) << $urandom_range(0, 3);
        if (kind == 3 && k == 1) begin
          mask = 4'($urandom_range(3, 15));
          while ($countones(mask) < 2) mask = 4'($urandom_range(3, 15));
        end
        do_press(mask, 1'b1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

`ifdef SAFECRACK_REPROG_EN
    // Reprogram from OPEN to 3,3,1,0. Then the old code fails and the new code opens
    do_reset();
    do_press(4'b0001, 1'b1);
    do_press(4'b0010, 1'b1);
    do_press(4'b0100, 1'b1);
    do_press(4'b1000, 1'b0);
    prog_req = 1'b1;
    @(negedge clk) prog_req = 1'b0;
    m_prog = 1'b1;
    check("prog_entry", 32'(leds_verde), 32'h0);
    enter_code(3, 3, 1, 0);
    enter_code(0, 1, 2, 3);
    enter_code(3, 3, 1, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
